// File: rtl/vx_dispatch_pkg.sv
// Shared types for the block-dispatch controller: FSM states, per-core owner
// entry and the group-size round-up helper.
package vx_dispatch_pkg;

    // Owner field is sized for the widest supported block id; narrower ids zero-extend.
    localparam int unsigned VX_NB_WIDTH     = 4;
    localparam int unsigned VX_MAX_NB_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic                       free;
        logic [VX_MAX_NB_WIDTH-1:0] owner;
    } owner_entry_t;

    function automatic int unsigned pow2_roundup(input int unsigned v);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < 31; i++) begin
            if (p < v) p = p << 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/vx_block_dispatch_ctrl_if.sv
// Block-dispatch bus: request channel from the scheduler plus the completion broadcast.
interface vx_block_dispatch_ctrl_if #(
    parameter int unsigned NB_WIDTH = 4,
    parameter int unsigned NC_WIDTH = 2
) ();

    logic                req_valid;
    logic                req_ready;
    logic [NB_WIDTH-1:0] req_id;
    logic [NC_WIDTH-1:0] req_size_m1;
    logic [NC_WIDTH-1:0] req_core_id;
    logic                rsp_valid;
    logic [NB_WIDTH-1:0] rsp_id;

    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input  req_ready, rsp_valid, rsp_id
    );

    modport slave (
        input  req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id
    );

endinterface

// File: rtl/vx_core_group_alloc.sv
// Combinational allocator: finds the lowest G-aligned group of G free cores.
module vx_core_group_alloc #(
    parameter  int unsigned NUM_CORES = 4,
    localparam int unsigned NC_WIDTH  = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] free_i,
    input  logic [NC_WIDTH:0]    gsize_i,
    output logic                 found_o,
    output logic [NC_WIDTH-1:0]  base_o
);

    int unsigned g;
    logic        grp_ok;

    always_comb begin
        found_o = 1'b0;
        base_o  = '0;
        g       = 32'(gsize_i);
        grp_ok  = 1'b0;
        for (int unsigned b = 0; b < NUM_CORES; b++) begin
            grp_ok = ((b & (g - 1)) == 0) && (b + g <= NUM_CORES);
            for (int unsigned k = 0; k < NUM_CORES; k++) begin
                if (k >= b && k < b + g && !free_i[k]) grp_ok = 1'b0;
            end
            if (grp_ok && !found_o) begin
                found_o = 1'b1;
                base_o  = NC_WIDTH'(b);
            end
        end
    end

endmodule

// File: rtl/vx_block_dispatch_ctrl.sv
// Kernel-launch scheduler: walks block ids, allocates aligned core groups,
// issues dispatch requests and retires blocks on completion broadcasts.
module vx_block_dispatch_ctrl
    import vx_dispatch_pkg::*;
#(
    parameter  int unsigned NUM_CORES = 4,
    parameter  int unsigned NB_WIDTH  = VX_NB_WIDTH,
    localparam int unsigned NC_WIDTH  = $clog2(NUM_CORES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NB_WIDTH:0]       start_num_blocks,
    input  logic [NC_WIDTH-1:0]     start_size_m1,
    output logic                    busy,
    output logic                    done,
    vx_block_dispatch_ctrl_if.master bus
);

    state_e              state_q, state_d;
    logic [NB_WIDTH:0]   num_q, num_d;
    logic [NB_WIDTH:0]   next_id_q, next_id_d;
    logic [NB_WIDTH:0]   next_id_inc;
    logic [NC_WIDTH-1:0] size_q, size_d;
    logic [NC_WIDTH:0]   gsize_q, gsize_d;
    logic [NB_WIDTH-1:0] req_id_q, req_id_d;
    logic [NC_WIDTH-1:0] req_core_q, req_core_d;
    logic [NC_WIDTH-1:0] req_size_q, req_size_d;
    owner_entry_t        tbl_q [NUM_CORES];
    owner_entry_t        tbl_d [NUM_CORES];

    logic [NUM_CORES-1:0] free_mask;
    logic                 alloc_found;
    logic [NC_WIDTH-1:0]  alloc_base;
    logic                 handshake;
    int unsigned          grp_lo, grp_hi;

    always_comb begin
        free_mask = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            free_mask[c] = tbl_q[c].free;
        end
    end

    vx_core_group_alloc #(
        .NUM_CORES (NUM_CORES)
    ) u_alloc (
        .free_i  (free_mask),
        .gsize_i (gsize_q),
        .found_o (alloc_found),
        .base_o  (alloc_base)
    );

    assign bus.req_valid   = (state_q == S_ISSUE);
    assign bus.req_id      = req_id_q;
    assign bus.req_core_id = req_core_q;
    assign bus.req_size_m1 = req_size_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign handshake       = bus.req_valid && bus.req_ready;
    assign next_id_inc     = next_id_q + (NB_WIDTH+1)'(1);

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        next_id_d  = next_id_q;
        size_d     = size_q;
        gsize_d    = gsize_q;
        req_id_d   = req_id_q;
        req_core_d = req_core_q;
        req_size_d = req_size_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d     = start_num_blocks;
                    size_d    = start_size_m1;
                    gsize_d   = (NC_WIDTH+1)'(pow2_roundup(32'(start_size_m1) + 32'd1));
                    next_id_d = '0;
                    // An empty launch passes through the (already empty) DRAIN so done
                    // lands two cycles after start, matching request latency.
                    state_d   = (start_num_blocks == '0) ? S_DRAIN : S_ALLOC;
                end
            end
            S_ALLOC: begin
                if (alloc_found) begin
                    req_id_d   = next_id_q[NB_WIDTH-1:0];
                    req_core_d = alloc_base;
                    req_size_d = size_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.req_ready) begin
                    next_id_d = next_id_inc;
                    state_d   = (next_id_inc == num_q) ? S_DRAIN : S_ALLOC;
                end
            end
            S_DRAIN: begin
                if (&free_mask) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake group and completing group are disjoint; handshake wins only for clarity.
    always_comb begin
        grp_lo = 32'(req_core_q);
        grp_hi = grp_lo + 32'(gsize_q);
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            tbl_d[c] = tbl_q[c];
            if (handshake && c >= grp_lo && c < grp_hi) begin
                tbl_d[c].free  = 1'b0;
                tbl_d[c].owner = VX_MAX_NB_WIDTH'(req_id_q);
            end else if (bus.rsp_valid && !tbl_q[c].free &&
                         tbl_q[c].owner == VX_MAX_NB_WIDTH'(bus.rsp_id)) begin
                tbl_d[c].free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            next_id_q  <= '0;
            size_q     <= '0;
            gsize_q    <= '0;
            req_id_q   <= '0;
            req_core_q <= '0;
            req_size_q <= '0;
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                tbl_q[c].free  <= 1'b1;
                tbl_q[c].owner <= '0;
            end
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            next_id_q  <= next_id_d;
            size_q     <= size_d;
            gsize_q    <= gsize_d;
            req_id_q   <= req_id_d;
            req_core_q <= req_core_d;
            req_size_q <= req_size_d;
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                tbl_q[c] <= tbl_d[c];
            end
        end
    end

endmodule

// File: tb/tb_vx_block_dispatch_ctrl.sv
// Bench for vx_block_dispatch_ctrl: directed scenarios plus random launches,
// checked by a queue scoreboard and a core-occupancy reference model.
module tb_vx_block_dispatch_ctrl;

    localparam int NUM_CORES = 4;
    localparam int NB_WIDTH  = 4;
    localparam int NC_WIDTH  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [NB_WIDTH:0]   start_num_blocks = '0;
    logic [NC_WIDTH-1:0] start_size_m1 = '0;
    logic                busy;
    logic                done;

    vx_block_dispatch_ctrl_if #(.NB_WIDTH(NB_WIDTH), .NC_WIDTH(NC_WIDTH)) bus ();

    vx_block_dispatch_ctrl #(.NUM_CORES(NUM_CORES), .NB_WIDTH(NB_WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_num_blocks (start_num_blocks),
        .start_size_m1    (start_size_m1),
        .busy             (busy),
        .done             (done),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int size; } req_t;
    req_t exp_q[$];
    int   outst_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int group_size(input int size_m1);
        int g;
        g = 1;
        while (g < size_m1 + 1) g = g * 2;
        return g;
    endfunction

    function automatic int ref_alloc(input bit fr [NUM_CORES], input int size_m1);
        int g;
        bit ok;
        g = group_size(size_m1);
        for (int b = 0; b + g <= NUM_CORES; b += g) begin
            ok = 1'b1;
            for (int k = b; k < b + g; k++) if (!fr[k]) ok = 1'b0;
            if (ok) return b;
        end
        return -1;
    endfunction

    // Reference model of core occupancy, advanced once per cycle.
    bit   m_free [NUM_CORES];
    int   m_owner[NUM_CORES];
    bit   p_free [NUM_CORES];
    bit   p_valid, p_hs, p_done;
    int   p_id, p_core, p_size;
    bit   mon_hs, all_free;
    int   exp_core, n_busy, g_sz;
    req_t e;

    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                m_free[c] = 1'b1; m_owner[c] = -1; p_free[c] = 1'b1;
            end
            p_valid = 1'b0; p_hs = 1'b0; p_done = 1'b0;
        end else begin
            mon_hs = bus.req_valid && bus.req_ready;
            if (bus.req_valid && !p_valid) begin
                check("req_has_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_core = ref_alloc(p_free, exp_q[0].size);
                    check("req_core", int'(bus.req_core_id), exp_core);
                end
            end
            if (bus.req_valid && p_valid && !p_hs) begin
                check("req_stable", int'(bus.req_id) * 64 + int'(bus.req_core_id) * 8 + int'(bus.req_size_m1),
                      p_id * 64 + p_core * 8 + p_size);
            end
            if (mon_hs && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_id", int'(bus.req_id), e.id);
                check("req_size", int'(bus.req_size_m1), e.size);
                g_sz = group_size(e.size);
                n_busy = 0;
                for (int k = int'(bus.req_core_id); k < int'(bus.req_core_id) + g_sz && k < NUM_CORES; k++)
                    if (!m_free[k]) n_busy++;
                check("grp_was_free", n_busy, 0);
            end
            if (done) begin
                all_free = 1'b1;
                for (int c = 0; c < NUM_CORES; c++) if (!m_free[c]) all_free = 1'b0;
                check("done_clean", int'(exp_q.size() == 0 && all_free), 1);
                check("done_single", int'(p_done), 0);
            end
            p_free = m_free;
            if (bus.rsp_valid) begin
                for (int c = 0; c < NUM_CORES; c++)
                    if (!m_free[c] && m_owner[c] == int'(bus.rsp_id)) m_free[c] = 1'b1;
            end
            if (mon_hs) begin
                g_sz = group_size(int'(bus.req_size_m1));
                for (int k = int'(bus.req_core_id); k < int'(bus.req_core_id) + g_sz && k < NUM_CORES; k++) begin
                    m_free[k] = 1'b0; m_owner[k] = int'(bus.req_id);
                end
                outst_q.push_back(int'(bus.req_id));
            end
            p_valid = bus.req_valid; p_hs = mon_hs; p_done = done;
            p_id = int'(bus.req_id); p_core = int'(bus.req_core_id); p_size = int'(bus.req_size_m1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the start pulse (cycle T+1).
    task automatic launch(input int n, input int sz);
        tick();
        check("idle_before_start", int'(busy), 0);
        for (int i = 0; i < n; i++) exp_q.push_back('{id: i, size: sz});
        start = 1'b1;
        start_num_blocks = (NB_WIDTH+1)'(n);
        start_size_m1 = NC_WIDTH'(sz);
        tick();
        start = 1'b0;
    endtask

    task automatic run_random(input int max_cyc, input int p_ready, input int p_rsp, input string nm);
        int got;
        int idx;
        got = 0;
        for (int cyc = 0; cyc < max_cyc && got == 0; cyc++) begin
            bus.req_ready = (int'($urandom_range(0, 99)) < p_ready);
            if (outst_q.size() > 0 && int'($urandom_range(0, 99)) < p_rsp) begin
                idx = int'($urandom_range(0, outst_q.size() - 1));
                bus.rsp_valid = 1'b1;
                bus.rsp_id = NB_WIDTH'(outst_q[idx]);
                outst_q.delete(idx);
            end else begin
                bus.rsp_valid = 1'b0;
            end
            tick();
            if (done) got = 1;
        end
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        check(nm, got, 1);
    endtask

    task automatic chk_req(input string nm, input int id, input int core);
        check({nm, "_valid"}, int'(bus.req_valid), 1);
        check({nm, "_id"}, int'(bus.req_id), id);
        check({nm, "_core"}, int'(bus.req_core_id), core);
    endtask

    task automatic send_rsp(input int id);
        bus.rsp_valid = 1'b1;
        bus.rsp_id = NB_WIDTH'(id);
        foreach (outst_q[i]) if (outst_q[i] == id) begin outst_q.delete(i); break; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int sid, scr, ssz;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_id = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(bus.req_valid), 0);
        check("rst_req_fields", int'(bus.req_id) + int'(bus.req_core_id) + int'(bus.req_size_m1), 0);
        reset = 1'b0;

        // Unit groups, always ready, no completions until all issued.
        bus.req_ready = 1'b1;
        launch(3, 0);
        check("t1_T1_valid", int'(bus.req_valid), 0);
        tick(); chk_req("t1_T2", 0, 0);
        tick(); check("t1_T3_valid", int'(bus.req_valid), 0);
        tick(); chk_req("t1_T4", 1, 1);
        tick(); tick(); chk_req("t1_T6", 2, 2);
        tick();
        bus.req_ready = 1'b0;
        repeat (4) tick();
        check("t1_drain_busy", int'(busy), 1);
        check("t1_drain_nodone", int'(done), 0);
        for (int i = 0; i < 3; i++) begin send_rsp(i); tick(); end
        bus.rsp_valid = 1'b0;
        check("t1_R1_done", int'(done), 0);
        tick(); check("t1_R2_done", int'(done), 1);
        tick(); check("t1_R3_done", int'(done), 0);
        check("t1_R3_busy", int'(busy), 0);

        // Full-width group: second block waits for the first to retire.
        bus.req_ready = 1'b1;
        launch(2, 2);
        tick(); chk_req("t2_T2", 0, 0);
        check("t2_size", int'(bus.req_size_m1), 2);
        for (int i = 0; i < 4; i++) begin tick(); check("t2_stall", int'(bus.req_valid), 0); end
        send_rsp(0);
        tick(); bus.rsp_valid = 1'b0;
        check("t2_C1_valid", int'(bus.req_valid), 0);
        tick(); chk_req("t2_C2", 1, 0);
        tick();
        run_random(200, 100, 100, "t2_done");

        // Pairs: blocks on cores 0 and 2; block 2 reuses the group freed by block 1.
        bus.req_ready = 1'b1;
        launch(3, 1);
        tick(); chk_req("t3_b0", 0, 0);
        tick(); tick(); chk_req("t3_b1", 1, 2);
        for (int i = 0; i < 3; i++) begin tick(); check("t3_stall", int'(bus.req_valid), 0); end
        send_rsp(1);
        tick(); bus.rsp_valid = 1'b0;
        tick(); chk_req("t3_b2", 2, 2);
        tick();
        run_random(200, 100, 100, "t3_done");

        // Backpressure: request held for five cycles, then accepted once.
        bus.req_ready = 1'b0;
        launch(2, 0);
        tick(); chk_req("t4_first", 0, 0);
        sid = int'(bus.req_id); scr = int'(bus.req_core_id); ssz = int'(bus.req_size_m1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_hold", int'(bus.req_valid) * 1000 + int'(bus.req_id) * 64 + int'(bus.req_core_id) * 8 + int'(bus.req_size_m1),
                  1000 + sid * 64 + scr * 8 + ssz);
        end
        bus.req_ready = 1'b1;
        tick(); check("t4_after_hs_valid", int'(bus.req_valid), 0);
        run_random(200, 100, 100, "t4_done");

        // Empty launch.
        launch(0, 0);
        check("t5_T1_done", int'(done), 0);
        tick(); check("t5_T2_done", int'(done), 1);
        check("t5_T2_valid", int'(bus.req_valid), 0);
        tick(); check("t5_T3_done", int'(done), 0);
        check("t5_T3_busy", int'(busy), 0);

        // Start while busy is ignored.
        bus.req_ready = 1'b0;
        launch(2, 0);
        start = 1'b1; start_num_blocks = 5'd5; start_size_m1 = 2'd3;
        tick(); start = 1'b0;
        tick();
        run_random(300, 100, 100, "t5_busy_done");

        // Reset in DRAIN aborts; stale completion afterwards changes nothing.
        bus.req_ready = 1'b1;
        launch(2, 0);
        repeat (5) tick();
        bus.req_ready = 1'b0;
        check("t6_in_drain_busy", int'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        outst_q.delete();
        tick();
        reset = 1'b0;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_valid", int'(bus.req_valid), 0);
        check("t6_rst_fields", int'(bus.req_id) + int'(bus.req_core_id) + int'(bus.req_size_m1), 0);
        bus.rsp_valid = 1'b1; bus.rsp_id = '0;
        tick(); bus.rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_stale_quiet", int'(busy) + int'(done) + int'(bus.req_valid), 0);
        end
        bus.req_ready = 1'b1;
        launch(2, 0);
        run_random(200, 100, 100, "t6_fresh_done");

        // Random launches.
        for (int l = 0; l < 25; l++) begin
            launch(int'($urandom_range(0, 16)), int'($urandom_range(0, 3)));
            run_random(1500, 60, 35, "rnd_done");
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
